uart_iram_loader: RTL and testbench

//  Boot-loader controller between the UART rx/tx FIFOs and the micro's instruction-RAM write port.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/ldr_timeout.sv | 33 +++
 rtl/uart_iram_loader.sv | 197 +++++++++++++++++++
 tb/tb_uart_iram_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared constants and FSM state type for the UART instruction-RAM boot loader.
//   SYNC_BYTE : packet start marker
//   ACK_BYTE  : response sent when the checksum matches
//   NAK_BYTE  : response sent on checksum mismatch or mid-packet timeout
package loader_pkg;

   localparam int unsigned BYTE_W = 8;

   localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;
   localparam logic [BYTE_W-1:0] ACK_BYTE  = 8'h06;
   localparam logic [BYTE_W-1:0] NAK_BYTE  = 8'h15;

   typedef enum logic [2:0] {
      IDLE,
      CNT,
      DHI,
      DLO,
      CSUM,
      RESP
   } ldr_state_t;

endpackage

// File: rtl/ldr_timeout.sv
// Idle-cycle watchdog for the loader: counts enabled cycles since the last clear.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart the count (a byte was consumed)
//   enable    : count this cycle (packet in progress and waiting on rx)
//   expired_c : TIMEOUT_CYC enabled cycles have elapsed without a clear
module ldr_timeout #(
   parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired_c
);

   localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [CW-1:0] count;

   // Expires on the TIMEOUT_CYC-th idle cycle; the count then holds until cleared.
   assign expired_c = enable && (count == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear || !enable) begin
         count <= '0;
      end else if (!expired_c) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/uart_iram_loader.sv
// Boot loader between the UART rx/tx FIFOs and the instruction-RAM write port.
// Parses A5 | N | {hi,lo} x (N+1) | CSUM, writes big-endian words from address 0,
// holds the CPU while loading and answers ACK/NAK on tx.
//   rx_empty, r_data, rd_uart : rx FIFO (show-ahead head byte, pop pulse)
//   tx_full, w_data, wr_uart  : tx FIFO (response byte, push pulse)
//   iram_wa, iram_din, iram_wen : IRAM write port (registered single-cycle pulse)
//   cpu_hold : micro held while loading or after a NAK
//   busy     : packet in progress
//   err      : sticky, last packet NAKed; cleared by the next ACK
module uart_iram_loader
   import loader_pkg::*;
#(
   parameter int unsigned WIDTH          = 16,
   parameter int unsigned IRAM_ADDR_BITS = 8,
   parameter int unsigned TIMEOUT_CYC    = 5_000_000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx_empty,
   input  logic [BYTE_W-1:0]         r_data,
   output logic                      rd_uart,
   input  logic                      tx_full,
   output logic [BYTE_W-1:0]         w_data,
   output logic                      wr_uart,
   output logic [IRAM_ADDR_BITS-1:0] iram_wa,
   output logic [WIDTH-1:0]          iram_din,
   output logic                      iram_wen,
   output logic                      cpu_hold,
   output logic                      busy,
   output logic                      err
);

   ldr_state_t                state, state_nx;
   logic                      pop;
   logic                      tmr_en;
   logic                      tmr_exp;
   logic [BYTE_W-1:0]         word_cnt;
   logic [BYTE_W-1:0]         csum;
   logic [BYTE_W-1:0]         hi_byte;
   logic [BYTE_W-1:0]         resp_code;
   logic [IRAM_ADDR_BITS-1:0] addr;

   // Byte pops are gated by rst so nothing leaves the FIFO while held in reset.
   assign rd_uart = pop && !rst;
   assign w_data  = resp_code;
   assign busy    = (state != IDLE);

   ldr_timeout #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clear    (pop),
      .enable   (tmr_en),
      .expired_c(tmr_exp)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state, byte pop and tx push
   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      wr_uart  = 1'b0;
      tmr_en   = 1'b0;
      unique case (state)
         IDLE: begin
            if (!rx_empty) begin
               pop = 1'b1;
               if (r_data == SYNC_BYTE) state_nx = CNT;
            end
         end
         CNT: begin
            tmr_en = 1'b1;
            if (!rx_empty) begin
               pop      = 1'b1;
               state_nx = DHI;
            end else if (tmr_exp) begin
               state_nx = RESP;
            end
         end
         DHI: begin
            tmr_en = 1'b1;
            if (!rx_empty) begin
               pop      = 1'b1;
               state_nx = DLO;
            end else if (tmr_exp) begin
               state_nx = RESP;
            end
         end
         DLO: begin
            tmr_en = 1'b1;
            if (!rx_empty) begin
               pop      = 1'b1;
               state_nx = (word_cnt == '0) ? CSUM : DHI;
            end else if (tmr_exp) begin
               state_nx = RESP;
            end
         end
         CSUM: begin
            tmr_en = 1'b1;
            if (!rx_empty) begin
               pop      = 1'b1;
               state_nx = RESP;
            end else if (tmr_exp) begin
               state_nx = RESP;
            end
         end
         RESP: begin
            if (!tx_full) begin
               wr_uart  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: word assembly, checksum, address and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt  <= '0;
         csum      <= '0;
         hi_byte   <= '0;
         resp_code <= '0;
         addr      <= '0;
         iram_wa   <= '0;
         iram_din  <= '0;
         iram_wen  <= 1'b0;
         cpu_hold  <= 1'b0;
         err       <= 1'b0;
      end else begin
         iram_wen <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pop && (r_data == SYNC_BYTE)) cpu_hold <= 1'b1;
            end
            CNT: begin
               if (pop) begin
                  word_cnt <= r_data;
                  addr     <= '0;
                  csum     <= '0;
               end else if (tmr_exp) begin
                  resp_code <= NAK_BYTE;
               end
            end
            DHI: begin
               if (pop) begin
                  hi_byte <= r_data;
                  csum    <= csum + r_data;
               end else if (tmr_exp) begin
                  resp_code <= NAK_BYTE;
               end
            end
            DLO: begin
               if (pop) begin
                  csum     <= csum + r_data;
                  iram_wen <= 1'b1;
                  iram_wa  <= addr;
                  iram_din <= WIDTH'({hi_byte, r_data});
                  addr     <= addr + IRAM_ADDR_BITS'(1);
                  word_cnt <= word_cnt - BYTE_W'(1);
               end else if (tmr_exp) begin
                  resp_code <= NAK_BYTE;
               end
            end
            CSUM: begin
               if (pop) begin
                  resp_code <= (r_data == csum) ? ACK_BYTE : NAK_BYTE;
               end else if (tmr_exp) begin
                  resp_code <= NAK_BYTE;
               end
            end
            RESP: begin
               // A NAK leaves the CPU held so a half-loaded image never runs.
               if (!tx_full) begin
                  if (resp_code == ACK_BYTE) begin
                     cpu_hold <= 1'b0;
                     err      <= 1'b0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_iram_loader.sv
// Self-checking bench for uart_iram_loader with an rx FIFO model (random pop gaps),
// a tx FIFO model and an IRAM write recorder.
module tb_uart_iram_loader;

   logic        clk;
   logic        rst;
   logic        rx_empty;
   logic [7:0]  r_data;
   logic        rd_uart;
   logic        tx_full;
   logic [7:0]  w_data;
   logic        wr_uart;
   logic [7:0]  iram_wa;
   logic [15:0] iram_din;
   logic        iram_wen;
   logic        cpu_hold;
   logic        busy;
   logic        err;

   uart_iram_loader #(
      .WIDTH(16),
      .IRAM_ADDR_BITS(8),
      .TIMEOUT_CYC(1000)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .rx_empty(rx_empty),
      .r_data  (r_data),
      .rd_uart (rd_uart),
      .tx_full (tx_full),
      .w_data  (w_data),
      .wr_uart (wr_uart),
      .iram_wa (iram_wa),
      .iram_din(iram_din),
      .iram_wen(iram_wen),
      .cpu_hold(cpu_hold),
      .busy    (busy),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  rx_q[$];
   logic [7:0]  tx_q[$];
   logic [7:0]  wa_q[$];
   logic [15:0] wd_q[$];
   int          cyc = 0;
   int          pop_cyc = 0;
   int          tx_cyc = 0;
   int          proto_err = 0;
   bit          hold_seen = 0;
   bit          gaps_on = 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // rx FIFO head presentation, with random empty gaps
   always @(negedge clk) begin
      bit gap;
      gap = gaps_on && ($urandom_range(0, 2) == 0);
      rx_empty = gap || (rx_q.size() == 0);
      r_data   = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
   end

   // FIFO pops/pushes and IRAM write recording on the active edge
   always @(posedge clk) begin
      if (rd_uart) begin
         if (rx_empty || rx_q.size() == 0) proto_err++;
         else void'(rx_q.pop_front());
         pop_cyc = cyc;
      end
      if (wr_uart) begin
         if (tx_full) proto_err++;
         tx_q.push_back(w_data);
         tx_cyc = cyc;
      end
      if (iram_wen) begin
         wa_q.push_back(iram_wa);
         wd_q.push_back(iram_din);
      end
      if (cpu_hold) hold_seen = 1;
      cyc++;
   end

   task automatic wait_tx(input string name);
      int n = 0;
      while (tx_q.size() == 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(tx_q.size()), 32'd1);
   endtask

   task automatic clear_logs();
      wa_q.delete();
      wd_q.delete();
      tx_q.delete();
      hold_seen = 0;
   endtask

   typedef struct {
      int          nb;
      logic [7:0]  b [12];
      int          nw;
      logic [15:0] w [2];
      logic [7:0]  resp;
      logic        err;
      logic        hold;
   } vec_t;

   vec_t vecs [4];

   initial begin
      logic [7:0] sum;
      int         n;

      // Frame: two words 1234, ABCD; checksum 12+34+AB+CD = 1BE -> BE
      vecs[0].nb = 7;
      vecs[0].b  = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
      vecs[0].nw = 2; vecs[0].w = '{16'h1234, 16'hABCD};
      vecs[0].resp = 8'h06; vecs[0].err = 1'b0; vecs[0].hold = 1'b0;
      // Bad checksum: one word written, NAK, CPU stays held
      vecs[1].nb = 5;
      vecs[1].b  = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
      vecs[1].nw = 1; vecs[1].w = '{16'h1234, 16'h0000};
      vecs[1].resp = 8'h15; vecs[1].err = 1'b1; vecs[1].hold = 1'b1;
      // Good frame clears the NAK
      vecs[2] = vecs[0];
      // Leading noise, then good frame
      vecs[3].nb = 10;
      vecs[3].b  = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h0, 8'h0};
      vecs[3].nw = 2; vecs[3].w = '{16'h1234, 16'hABCD};
      vecs[3].resp = 8'h06; vecs[3].err = 1'b0; vecs[3].hold = 1'b0;

      rst = 1'b1; tx_full = 1'b0; rx_empty = 1'b1; r_data = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_cpu_hold", 32'(cpu_hold), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_err", 32'(err), 32'd0);
      check("reset_wen", 32'(iram_wen), 32'd0);
      check("reset_wdata", 32'(w_data), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 4; v++) begin
         clear_logs();
         for (int i = 0; i < vecs[v].nb; i++) rx_q.push_back(vecs[v].b[i]);
         wait_tx($sformatf("v%0d_tx_count", v));
         repeat (2) @(negedge clk);
         check($sformatf("v%0d_resp", v), 32'(tx_q.size() != 0 ? tx_q[0] : 8'hXX), 32'(vecs[v].resp));
         check($sformatf("v%0d_nwrites", v), 32'(wa_q.size()), 32'(vecs[v].nw));
         for (int i = 0; i < vecs[v].nw && i < wa_q.size(); i++) begin
            check($sformatf("v%0d_wa%0d", v, i), 32'(wa_q[i]), 32'(i));
            check($sformatf("v%0d_wd%0d", v, i), 32'(wd_q[i]), 32'(vecs[v].w[i]));
         end
         check($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].err));
         check($sformatf("v%0d_hold", v), 32'(cpu_hold), 32'(vecs[v].hold));
         check($sformatf("v%0d_hold_seen", v), 32'(hold_seen), 32'd1);
         check($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
      end

      // Timeout: packet stalls after the first hi byte
      clear_logs();
      rx_q.push_back(8'hA5); rx_q.push_back(8'h01); rx_q.push_back(8'h12);
      wait_tx("to_tx_count");
      repeat (2) @(negedge clk);
      check("to_resp", 32'(tx_q.size() != 0 ? tx_q[0] : 8'hXX), 32'h15);
      check("to_latency", 32'(tx_cyc - pop_cyc), 32'd1001);
      check("to_nwrites", 32'(wa_q.size()), 32'd0);
      check("to_busy", 32'(busy), 32'd0);
      check("to_err", 32'(err), 32'd1);
      check("to_hold", 32'(cpu_hold), 32'd1);

      // 256 words of value i, addresses 0..255
      clear_logs();
      sum = 8'h00;
      rx_q.push_back(8'hA5); rx_q.push_back(8'hFF);
      for (int i = 0; i < 256; i++) begin
         rx_q.push_back(8'h00);
         rx_q.push_back(8'(i));
         sum = sum + 8'(i);
      end
      rx_q.push_back(sum);
      wait_tx("full_tx_count");
      repeat (2) @(negedge clk);
      check("full_resp", 32'(tx_q.size() != 0 ? tx_q[0] : 8'hXX), 32'h06);
      check("full_nwrites", 32'(wa_q.size()), 32'd256);
      for (int i = 0; i < 256 && i < wa_q.size(); i++) begin
         check($sformatf("full_wa%0d", i), 32'(wa_q[i]), 32'(i));
         check($sformatf("full_wd%0d", i), 32'(wd_q[i]), 32'(i));
      end
      check("full_err", 32'(err), 32'd0);
      check("full_hold", 32'(cpu_hold), 32'd0);

      // tx FIFO full while the response is pending
      clear_logs();
      tx_full = 1'b1;
      for (int i = 0; i < vecs[0].nb; i++) rx_q.push_back(vecs[0].b[i]);
      n = 0;
      while (rx_q.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("txf_rx_drained", 32'(rx_q.size()), 32'd0);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (wr_uart) n++;
      end
      check("txf_no_push", 32'(n), 32'd0);
      check("txf_tx_empty", 32'(tx_q.size()), 32'd0);
      check("txf_busy", 32'(busy), 32'd1);
      tx_full = 1'b0;
      wait_tx("txf_tx_count");
      repeat (3) @(negedge clk);
      check("txf_one_push", 32'(tx_q.size()), 32'd1);
      check("txf_resp", 32'(tx_q.size() != 0 ? tx_q[0] : 8'hXX), 32'h06);

      // Reset in the middle of a packet (waiting for a hi byte)
      clear_logs();
      rx_q.push_back(8'hA5); rx_q.push_back(8'h01); rx_q.push_back(8'h12);
      rx_q.push_back(8'h34);
      n = 0;
      while (rx_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check("rst_pre_busy", 32'(busy), 32'd1);
      check("rst_pre_hold", 32'(cpu_hold), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_hold", 32'(cpu_hold), 32'd0);
      check("rst_rd", 32'(rd_uart), 32'd0);
      check("rst_wr", 32'(wr_uart), 32'd0);
      check("rst_wen", 32'(iram_wen), 32'd0);
      check("rst_wa", 32'(iram_wa), 32'd0);
      check("rst_din", 32'(iram_din), 32'd0);
      check("rst_wdata", 32'(w_data), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_no_response", 32'(tx_q.size()), 32'd0);
      check("rst_partial_write", 32'(wa_q.size()), 32'd1);

      check("fifo_protocol", 32'(proto_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
